// File: rtl/prog_fetch_ctrl.sv
// Program loader and fetch sequencer: streams bytes into program memory, then steps PC.
// Optional halt-opcode stop is enabled by defining PROG_FETCH_CTRL_HALT_OPCODE_EN.
module prog_fetch_ctrl #(
    parameter int          DEPTH       = 32,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF,
    localparam int         PW          = $clog2(DEPTH)
) (
    input  logic          CPU_Clk,
    input  logic          Reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          fifo_clr,
    output logic          fifo_wr,
    output logic [7:0]    fifo_data,
    input  logic          fifo_full,
    input  logic [7:0]    instr,
    input  logic          run_start,
    input  logic          pc_inc,
    input  logic          jmp_en,
    input  logic [PW-1:0] jmp_addr,
    output logic [PW-1:0] PC,
    output logic [PW:0]   prog_len,
    output logic          fetch_valid,
    output logic          done,
    input  logic          abort_in
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW:0]   len_q, len_d;
    logic          halt;
    logic          last_pc;
    logic          jmp_oob;

    assign PC          = pc_q;
    assign prog_len    = len_q;
    assign fifo_data   = load_data;
    assign done        = (state_q == DONE);
    assign fetch_valid = (state_q == RUN) && ({1'b0, pc_q} < len_q);

    // Stepping off the last loaded byte (or the top of memory) ends the run.
    assign last_pc = (({1'b0, pc_q} + (PW+1)'(1)) >= len_q)
                   || (pc_q == PW'(DEPTH - 1));
    assign jmp_oob = ({1'b0, jmp_addr} >= len_q);

`ifdef PROG_FETCH_CTRL_HALT_OPCODE_EN
    assign halt = fetch_valid && (instr == HALT_OPCODE);
`else
    logic unused_halt;
    assign unused_halt = ^{instr, HALT_OPCODE};
    assign halt        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        load_ready = 1'b0;
        fifo_wr    = 1'b0;
        fifo_clr   = 1'b0;
        if (Reset || abort_in) begin
            state_d = IDLE;
            pc_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        fifo_clr = 1'b1;
                        len_d    = '0;
                        state_d  = LOAD;
                    end else if (run_start && (len_q != '0)) begin
                        pc_d    = '0;
                        state_d = RUN;
                    end
                end
                LOAD: begin
                    load_ready = !fifo_full;
                    fifo_wr    = load_valid && !fifo_full;
                    if (fifo_wr) begin
                        len_d = len_q + (PW+1)'(1);
                        if (load_last) begin
                            state_d = IDLE;
                        end
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_d = DONE;
                    end else if (jmp_en) begin
                        if (jmp_oob) begin
                            state_d = DONE;
                        end else begin
                            pc_d = jmp_addr;
                        end
                    end else if (pc_inc) begin
                        if (last_pc) begin
                            state_d = DONE;
                        end else begin
                            pc_d = pc_q + PW'(1);
                        end
                    end
                end
                DONE: begin
                    if (load_start) begin
                        fifo_clr = 1'b1;
                        len_d    = '0;
                        state_d  = LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CPU_Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
        end
    end

endmodule
